// File: rtl/fetch_history_unit_pkg.sv
// fetch_history_unit_pkg
//   Constants shared by the fetch stage and the decode unit: PC width,
//   the bubble encoding, instruction field positions and the fetch mode enum.
package fetch_history_unit_pkg;

   localparam int          PC_W     = 16;
   localparam logic [15:0] NOP_WORD = 16'hC0F0;   // ALU class, op 4'b1111

   // instruction field positions
   localparam int CLS_HI = 15, CLS_LO = 14;
   localparam int F1_HI  = 13, F1_LO  = 11;
   localparam int F2_HI  = 10, F2_LO  = 8;
   localparam int OP_HI  = 7,  OP_LO  = 4;

   typedef enum logic [1:0] {
      MODE_ADVANCE  = 2'd0,
      MODE_HOLD     = 2'd1,
      MODE_REDIRECT = 2'd2
   } fetch_mode_e;

endpackage

// File: rtl/fetch_history_unit_if.sv
// fetch_history_unit_if
//   Bus between the fetch stage and its environment (ROM + decode).
//   master : fetch stage (drives IMEM_ADDR and the command/history outputs)
//   slave  : environment (drives STALL, PC_LOAD, BRANCH_TARGET, IMEM_DATA)
interface fetch_history_unit_if #(
   parameter int PC_W = fetch_history_unit_pkg::PC_W
);
   logic            STALL;
   logic            PC_LOAD;
   logic [PC_W-1:0] BRANCH_TARGET;
   logic [PC_W-1:0] IMEM_ADDR;
   logic [15:0]     IMEM_DATA;
   logic [15:0]     COMMAND;
   logic [15:0]     BeforeCOMMAND;
   logic [15:0]     TwoBeforeCOMMAND;
   logic [PC_W-1:0] PC_OUT;
   logic [15:0]     RETIRED;

   modport master (
      input  STALL, PC_LOAD, BRANCH_TARGET, IMEM_DATA,
      output IMEM_ADDR, COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND, PC_OUT, RETIRED
   );

   modport slave (
      output STALL, PC_LOAD, BRANCH_TARGET, IMEM_DATA,
      input  IMEM_ADDR, COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND, PC_OUT, RETIRED
   );
endinterface

// File: rtl/fetch_history_unit.sv
// fetch_history_unit
//   Instruction fetch stage feeding decode. Owns the PC, drives a ROM with
//   one-cycle read latency and presents COMMAND plus the two previously
//   issued words for forwarding. Handles stalls and taken-branch redirects.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fetch_history_unit_if.master (STALL, PC_LOAD, BRANCH_TARGET,
//          IMEM_ADDR, IMEM_DATA, COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND,
//          PC_OUT, RETIRED)
module fetch_history_unit
   import fetch_history_unit_pkg::*;
#(
   parameter int          PC_W     = fetch_history_unit_pkg::PC_W,
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_WORD = fetch_history_unit_pkg::NOP_WORD
) (
   input  logic                       clk,
   input  logic                       rst,
   fetch_history_unit_if.master       bus
);

   localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] ONE    = PC_W'(1);

   fetch_mode_e     mode;
   logic [PC_W-1:0] fpc_q, fpc_d, ipc_q, ipc_d, cpc_q, cpc_d;
   logic            ivalid_q, ivalid_d, cvalid_q, cvalid_d;
   logic [15:0]     cmd_q, cmd_d, b1_q, b1_d, b2_q, b2_d;
   logic [15:0]     ret_q, ret_d;
   logic [PC_W-1:0] imem_addr;

   always_comb begin
      mode = MODE_ADVANCE;
      if (bus.PC_LOAD)    mode = MODE_REDIRECT;
      else if (bus.STALL) mode = MODE_HOLD;
   end

   always_comb begin
      fpc_d    = fpc_q;
      ipc_d    = ipc_q;
      cpc_d    = cpc_q;
      ivalid_d = ivalid_q;
      cvalid_d = cvalid_q;
      cmd_d    = cmd_q;
      b1_d     = b1_q;
      b2_d     = b2_q;
      ret_d    = ret_q;
      imem_addr = fpc_q;
      case (mode)
         MODE_REDIRECT: begin
            // word in flight from the ROM belongs to the wrong path: drop it
            imem_addr = bus.BRANCH_TARGET;
            cmd_d     = NOP_WORD;
            cvalid_d  = 1'b0;
            cpc_d     = bus.BRANCH_TARGET;
            b1_d      = cmd_q;
            b2_d      = b1_q;
            ipc_d     = bus.BRANCH_TARGET;
            ivalid_d  = 1'b1;
            fpc_d     = bus.BRANCH_TARGET + ONE;
            ret_d     = ret_q + 16'(cvalid_q);
         end
         MODE_HOLD: begin
            // re-read ipc so IMEM_DATA is still the pending word next cycle;
            // downstream sees a bubble, so history records one
            imem_addr = ipc_q;
            b1_d      = NOP_WORD;
            b2_d      = b1_q;
         end
         default: begin
            imem_addr = fpc_q;
            cmd_d     = ivalid_q ? bus.IMEM_DATA : NOP_WORD;
            cvalid_d  = ivalid_q;
            cpc_d     = ipc_q;
            b1_d      = cmd_q;
            b2_d      = b1_q;
            ipc_d     = fpc_q;
            ivalid_d  = 1'b1;
            fpc_d     = fpc_q + ONE;
            ret_d     = ret_q + 16'(cvalid_q);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q    <= RST_PC;
         ipc_q    <= RST_PC;
         cpc_q    <= RST_PC;
         ivalid_q <= 1'b0;
         cvalid_q <= 1'b0;
         cmd_q    <= NOP_WORD;
         b1_q     <= NOP_WORD;
         b2_q     <= NOP_WORD;
         ret_q    <= 16'd0;
      end else begin
         fpc_q    <= fpc_d;
         ipc_q    <= ipc_d;
         cpc_q    <= cpc_d;
         ivalid_q <= ivalid_d;
         cvalid_q <= cvalid_d;
         cmd_q    <= cmd_d;
         b1_q     <= b1_d;
         b2_q     <= b2_d;
         ret_q    <= ret_d;
      end
   end

   assign bus.IMEM_ADDR        = imem_addr;
   assign bus.COMMAND          = cmd_q;
   assign bus.BeforeCOMMAND    = b1_q;
   assign bus.TwoBeforeCOMMAND = b2_q;
   assign bus.PC_OUT           = cpc_q;
   assign bus.RETIRED          = ret_q;

endmodule

// File: tb/tb_fetch_history_unit.sv
// tb_fetch_history_unit
//   Directed scenarios plus a randomized run against a slot/queue model of
//   the fetch stream: a fetched slot, a command slot and the list of words
//   sent downstream.
module tb_fetch_history_unit;
   import fetch_history_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_history_unit_if bus();

   fetch_history_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   logic [15:0] rom [0:65535];
   always @(posedge clk) bus.IMEM_DATA <= rom[bus.IMEM_ADDR];

   int n_vec = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   logic [15:0] m_next, m_f_a, m_c_a, m_ret;
   bit          m_f_v, m_c_v;
   logic [15:0] m_hist[$];          // words sent downstream, oldest first
   logic [15:0] addr_seen, addr_exp;

   function automatic logic [15:0] m_cmd();
      return m_c_v ? rom[m_c_a] : NOP_WORD;
   endfunction

   function automatic logic [15:0] m_addr(bit st, bit ld, logic [15:0] tgt);
      if (ld) return tgt;
      if (st) return m_f_a;
      return m_next;
   endfunction

   task automatic model_step(bit st, bit ld, logic [15:0] tgt, bit r);
      if (r) begin
         m_next = 16'h0000; m_f_a = 16'h0000; m_c_a = 16'h0000;
         m_f_v = 0; m_c_v = 0; m_ret = 0;
         m_hist = {NOP_WORD, NOP_WORD};
      end else if (ld) begin
         m_hist.push_back(m_cmd());
         m_ret += 16'(m_c_v);
         m_c_a = tgt; m_c_v = 0;
         m_f_a = tgt; m_f_v = 1;
         m_next = tgt + 16'd1;
      end else if (st) begin
         m_hist.push_back(NOP_WORD);
      end else begin
         m_hist.push_back(m_cmd());
         m_ret += 16'(m_c_v);
         m_c_a = m_f_a; m_c_v = m_f_v;
         m_f_a = m_next; m_f_v = 1;
         m_next = m_next + 16'd1;
      end
      while (m_hist.size() > 2) void'(m_hist.pop_front());
   endtask

   // applies one cycle of inputs; samples IMEM_ADDR before the edge
   task automatic tick(bit st, bit ld, logic [15:0] tgt, bit r);
      @(negedge clk);
      rst = r; bus.STALL = st; bus.PC_LOAD = ld; bus.BRANCH_TARGET = tgt;
      #1;
      addr_seen = bus.IMEM_ADDR;
      addr_exp  = m_addr(st, ld, tgt);
      @(posedge clk);
      model_step(st, ld, tgt, r);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      tick(0, 0, 0, 1);
      tick(1, 1, 16'h1234, 1);
      n_vec++; if (bus.COMMAND !== NOP_WORD) begin n_bad++; $display("FAIL reset_cmd got %h want %h", bus.COMMAND, NOP_WORD); end
      n_vec++; if (bus.BeforeCOMMAND !== NOP_WORD || bus.TwoBeforeCOMMAND !== NOP_WORD) begin n_bad++; $display("FAIL reset_hist got %h/%h want %h", bus.BeforeCOMMAND, bus.TwoBeforeCOMMAND, NOP_WORD); end
      n_vec++; if (bus.PC_OUT !== 16'h0000 || bus.RETIRED !== 16'd0) begin n_bad++; $display("FAIL reset_pc_ret got %h/%0d want 0000/0", bus.PC_OUT, bus.RETIRED); end
   endtask

   task automatic test_startup();
      for (int k = 1; k <= 4; k++) begin
         logic [15:0] ec, eb, e2, ep;
         tick(0, 0, 0, 0);
         ec = (k == 1) ? NOP_WORD : 16'h8000 + 16'(k - 2);
         eb = (k <= 2) ? NOP_WORD : 16'h8000 + 16'(k - 3);
         e2 = (k <= 3) ? NOP_WORD : 16'h8000 + 16'(k - 4);
         ep = (k == 1) ? 16'h0000 : 16'(k - 2);
         n_vec++; if (addr_seen !== 16'(k - 1)) begin n_bad++; $display("FAIL start_addr%0d got %h want %h", k, addr_seen, 16'(k - 1)); end
         n_vec++; if (bus.COMMAND !== ec || bus.PC_OUT !== ep) begin n_bad++; $display("FAIL start_cmd%0d got %h@%h want %h@%h", k, bus.COMMAND, bus.PC_OUT, ec, ep); end
         n_vec++; if (bus.BeforeCOMMAND !== eb || bus.TwoBeforeCOMMAND !== e2) begin n_bad++; $display("FAIL start_hist%0d got %h/%h want %h/%h", k, bus.BeforeCOMMAND, bus.TwoBeforeCOMMAND, eb, e2); end
         n_vec++; if (bus.RETIRED !== 16'((k <= 2) ? 0 : k - 2)) begin n_bad++; $display("FAIL start_ret%0d got %0d want %0d", k, bus.RETIRED, (k <= 2) ? 0 : k - 2); end
      end
   endtask

   task automatic test_stall();
      for (int k = 1; k <= 3; k++) begin
         tick(1, 0, 0, 0);
         n_vec++; if (addr_seen !== 16'h0003) begin n_bad++; $display("FAIL stall_addr%0d got %h want 0003", k, addr_seen); end
         n_vec++; if (bus.COMMAND !== 16'h8002 || bus.PC_OUT !== 16'h0002) begin n_bad++; $display("FAIL stall_cmd%0d got %h@%h want 8002@0002", k, bus.COMMAND, bus.PC_OUT); end
         n_vec++; if (bus.BeforeCOMMAND !== NOP_WORD || bus.TwoBeforeCOMMAND !== ((k == 1) ? 16'h8001 : NOP_WORD)) begin n_bad++; $display("FAIL stall_hist%0d got %h/%h", k, bus.BeforeCOMMAND, bus.TwoBeforeCOMMAND); end
         n_vec++; if (bus.RETIRED !== 16'd2) begin n_bad++; $display("FAIL stall_ret%0d got %0d want 2", k, bus.RETIRED); end
      end
      for (int k = 3; k <= 5; k++) begin
         tick(0, 0, 0, 0);
         n_vec++; if (addr_seen !== 16'(k + 1)) begin n_bad++; $display("FAIL unstall_addr got %h want %h", addr_seen, 16'(k + 1)); end
         n_vec++; if (bus.COMMAND !== 16'h8000 + 16'(k) || bus.PC_OUT !== 16'(k)) begin n_bad++; $display("FAIL unstall_cmd got %h@%h want %h", bus.COMMAND, bus.PC_OUT, 16'h8000 + 16'(k)); end
         n_vec++; if (bus.RETIRED !== m_ret) begin n_bad++; $display("FAIL unstall_ret got %0d want %0d", bus.RETIRED, m_ret); end
      end
      n_vec++; if (bus.BeforeCOMMAND !== 16'h8004 || bus.TwoBeforeCOMMAND !== 16'h8003) begin n_bad++; $display("FAIL unstall_hist got %h/%h want 8004/8003", bus.BeforeCOMMAND, bus.TwoBeforeCOMMAND); end
   endtask

   task automatic test_redirect();
      tick(0, 1, 16'h0040, 0);
      n_vec++; if (addr_seen !== 16'h0040) begin n_bad++; $display("FAIL redir_addr got %h want 0040", addr_seen); end
      n_vec++; if (bus.COMMAND !== NOP_WORD || bus.BeforeCOMMAND !== 16'h8005) begin n_bad++; $display("FAIL redir_bubble got %h/%h want %h/8005", bus.COMMAND, bus.BeforeCOMMAND, NOP_WORD); end
      tick(0, 0, 0, 0);
      n_vec++; if (addr_seen !== 16'h0041) begin n_bad++; $display("FAIL redir_addr2 got %h want 0041", addr_seen); end
      n_vec++; if (bus.COMMAND !== 16'h8040 || bus.PC_OUT !== 16'h0040) begin n_bad++; $display("FAIL redir_target got %h@%h want 8040@0040", bus.COMMAND, bus.PC_OUT); end
      n_vec++; if (bus.RETIRED !== m_ret) begin n_bad++; $display("FAIL redir_ret got %0d want %0d", bus.RETIRED, m_ret); end
   endtask

   task automatic test_redirect_stall();
      tick(1, 1, 16'h0080, 0);
      n_vec++; if (addr_seen !== 16'h0080) begin n_bad++; $display("FAIL rs_addr got %h want 0080", addr_seen); end
      n_vec++; if (bus.COMMAND !== NOP_WORD || bus.BeforeCOMMAND !== 16'h8040) begin n_bad++; $display("FAIL rs_bubble got %h/%h want %h/8040", bus.COMMAND, bus.BeforeCOMMAND, NOP_WORD); end
      tick(0, 0, 0, 0);
      n_vec++; if (bus.COMMAND !== 16'h8080 || bus.PC_OUT !== 16'h0080) begin n_bad++; $display("FAIL rs_target got %h@%h want 8080@0080", bus.COMMAND, bus.PC_OUT); end
   endtask

   task automatic test_back_to_back();
      tick(0, 1, 16'h0010, 0);
      tick(0, 1, 16'h0020, 0);
      n_vec++; if (addr_seen !== 16'h0020) begin n_bad++; $display("FAIL b2b_addr got %h want 0020", addr_seen); end
      n_vec++; if (bus.COMMAND !== NOP_WORD || bus.BeforeCOMMAND !== NOP_WORD) begin n_bad++; $display("FAIL b2b_bubbles got %h/%h want %h", bus.COMMAND, bus.BeforeCOMMAND, NOP_WORD); end
      tick(0, 0, 0, 0);
      n_vec++; if (bus.COMMAND !== 16'h8020 || bus.PC_OUT !== 16'h0020) begin n_bad++; $display("FAIL b2b_target got %h@%h want 8020@0020", bus.COMMAND, bus.PC_OUT); end
      tick(0, 0, 0, 0);
      n_vec++; if (bus.COMMAND !== 16'h8021) begin n_bad++; $display("FAIL b2b_next got %h want 8021", bus.COMMAND); end
   endtask

   task automatic test_wrap();
      tick(0, 1, 16'hFFFE, 0);
      for (int k = 0; k < 3; k++) begin
         tick(0, 0, 0, 0);
         n_vec++; if (addr_seen !== 16'hFFFF + 16'(k)) begin n_bad++; $display("FAIL wrap_addr%0d got %h want %h", k, addr_seen, 16'hFFFF + 16'(k)); end
         n_vec++; if (bus.PC_OUT !== 16'hFFFE + 16'(k) || bus.COMMAND !== 16'h7FFE + 16'(k)) begin n_bad++; $display("FAIL wrap_cmd%0d got %h@%h want %h@%h", k, bus.COMMAND, bus.PC_OUT, 16'h7FFE + 16'(k), 16'hFFFE + 16'(k)); end
      end
   endtask

   task automatic test_reset_mid();
      n_vec++; if (bus.RETIRED !== m_ret) begin n_bad++; $display("FAIL mid_ret_sb got %0d want %0d", bus.RETIRED, m_ret); end
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(1, 1, 16'h0055, 1);
      n_vec++; if (bus.COMMAND !== NOP_WORD || bus.BeforeCOMMAND !== NOP_WORD || bus.TwoBeforeCOMMAND !== NOP_WORD) begin n_bad++; $display("FAIL mid_stall_rst got %h/%h/%h", bus.COMMAND, bus.BeforeCOMMAND, bus.TwoBeforeCOMMAND); end
      n_vec++; if (bus.PC_OUT !== 16'h0000 || bus.RETIRED !== 16'd0) begin n_bad++; $display("FAIL mid_stall_rst_pc got %h/%0d want 0000/0", bus.PC_OUT, bus.RETIRED); end
      for (int k = 0; k < 4; k++) tick(0, 0, 0, 0);
      tick(0, 1, 16'h0030, 0);
      tick(0, 1, 16'h0050, 1);
      n_vec++; if (bus.COMMAND !== NOP_WORD || bus.BeforeCOMMAND !== NOP_WORD || bus.PC_OUT !== 16'h0000 || bus.RETIRED !== 16'd0) begin n_bad++; $display("FAIL mid_redir_rst got %h/%h@%h ret %0d", bus.COMMAND, bus.BeforeCOMMAND, bus.PC_OUT, bus.RETIRED); end
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      n_vec++; if (bus.COMMAND !== 16'h8000) begin n_bad++; $display("FAIL mid_redir_restart got %h want 8000", bus.COMMAND); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bit r  = ($urandom_range(0, 49) == 0);
         bit ld = ($urandom_range(0, 7) == 0);
         bit st = ($urandom_range(0, 3) == 0);
         logic [15:0] tgt = 16'($urandom());
         tick(st, ld, tgt, r);
         if (!r) begin
            n_vec++; if (addr_seen !== addr_exp) begin n_bad++; $display("FAIL rnd_addr[%0d] got %h want %h", i, addr_seen, addr_exp); end
         end
         n_vec++; if (bus.COMMAND !== m_cmd() || bus.PC_OUT !== m_c_a) begin n_bad++; $display("FAIL rnd_cmd[%0d] got %h@%h want %h@%h", i, bus.COMMAND, bus.PC_OUT, m_cmd(), m_c_a); end
         n_vec++; if (bus.BeforeCOMMAND !== m_hist[1] || bus.TwoBeforeCOMMAND !== m_hist[0]) begin n_bad++; $display("FAIL rnd_hist[%0d] got %h/%h want %h/%h", i, bus.BeforeCOMMAND, bus.TwoBeforeCOMMAND, m_hist[1], m_hist[0]); end
         n_vec++; if (bus.RETIRED !== m_ret) begin n_bad++; $display("FAIL rnd_ret[%0d] got %0d want %0d", i, bus.RETIRED, m_ret); end
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) rom[i] = 16'h8000 + 16'(i);
      rst = 1'b1; bus.STALL = 1'b0; bus.PC_LOAD = 1'b0; bus.BRANCH_TARGET = '0;
      test_reset();
      test_startup();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
